// File: rtl/test_cond_unit_if.sv
// Condition-evaluator bus: operand, condition code, capture enable and results.
// Optional TEST_COND_NEGATE_EN adds the neg input that inverts the decoded condition.
interface test_cond_unit_if #(
  parameter int WIDTH = 24
);
  logic [0:WIDTH-1] a;
  logic [2:0]       op;
  logic             ld;
`ifdef TEST_COND_NEGATE_EN
  logic             neg;
`endif
  logic             y;
  logic             y_q;

`ifdef TEST_COND_NEGATE_EN
  modport master (output a, output op, output ld, output neg, input y, input y_q);
  modport slave  (input a, input op, input ld, input neg, output y, output y_q);
`else
  modport master (output a, output op, output ld, input y, input y_q);
  modport slave  (input a, input op, input ld, output y, output y_q);
`endif
endinterface

// File: rtl/test_cond_unit.sv
// Condition evaluator for the execute stage: combinational y plus a captured copy y_q.
// Optional TEST_COND_NEGATE_EN inverts the decoded condition with the neg input.
module test_cond_unit #(
  parameter int WIDTH = 24
) (
  input logic              clk,
  input logic              rst_n,
  test_cond_unit_if.slave  bus
);

  // Operand uses big-endian bit numbering: a[0] is the sign, a[WIDTH-1] the LSB.
  function automatic logic cond_eval(input logic [0:WIDTH-1] a, input logic [2:0] op);
    logic z, n, p, odd;
    z   = (a == '0);
    n   = a[0];
    p   = ~n & ~z;
    odd = a[WIDTH-1];
    case (op)
      3'd0:    cond_eval = z;
      3'd1:    cond_eval = ~z;
      3'd2:    cond_eval = n;
      3'd3:    cond_eval = ~n;
      3'd4:    cond_eval = n | z;
      3'd5:    cond_eval = p;
      3'd6:    cond_eval = ~odd;
      default: cond_eval = odd;
    endcase
  endfunction

  logic y_p0;
  logic y_p1;

  always_comb begin
`ifdef TEST_COND_NEGATE_EN
    y_p0 = cond_eval(bus.a, bus.op) ^ bus.neg;
`else
    y_p0 = cond_eval(bus.a, bus.op);
`endif
  end

  // p0 -> p1: optional capture of the evaluated condition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p1 <= 1'b0;
    end else if (bus.ld) begin
      y_p1 <= y_p0;
    end
  end

  assign bus.y   = y_p0;
  assign bus.y_q = y_p1;

endmodule

// File: tb/tb_test_cond_unit.sv
// Scoreboard bench for test_cond_unit: expectations queued at drive time, popped on DUT output.
// Honours TEST_COND_NEGATE_EN when the design is built with it.
module tb_test_cond_unit;
  localparam int WIDTH = 24;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic  exp_q[$];
  string tag_q[$];

  test_cond_unit_if #(.WIDTH(WIDTH)) bus ();

  test_cond_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference model in conventional [23:0] numbering: bit 23 is sign, bit 0 is parity.
  function automatic logic model(input logic [31:0] v, input logic [2:0] op, input logic ng);
    logic [WIDTH-1:0] w;
    logic z, n, odd, r;
    w   = v[WIDTH-1:0];
    z   = (w == 0);
    n   = w[WIDTH-1];
    odd = w[0];
    case (op)
      3'd0: r = z;
      3'd1: r = !z;
      3'd2: r = n;
      3'd3: r = !n;
      3'd4: r = n || z;
      3'd5: r = !n && !z;
      3'd6: r = !odd;
      default: r = odd;
    endcase
    return r ^ ng;
  endfunction

  task automatic drive(input logic [31:0] v, input logic [2:0] op, input logic ng, input logic ld);
    bus.a  = v[WIDTH-1:0];
    bus.op = op;
    bus.ld = ld;
`ifdef TEST_COND_NEGATE_EN
    bus.neg = ng;
`endif
  endtask

  task automatic pop_check(input logic got);
    logic  e;
    string t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic comb(input string tag, input logic [31:0] v, input logic [2:0] op, input logic ng);
    drive(v, op, ng, 1'b0);
    exp_q.push_back(model(v, op, ng));
    tag_q.push_back($sformatf("%s a=%06h op=%0d neg=%0b", tag, v[WIDTH-1:0], op, ng));
    #1;
    pop_check(bus.y);
  endtask

  // Drive on negedge, compare y_q one step after the next rising edge.
  task automatic reg_step(input string tag, input logic [31:0] v, input logic [2:0] op,
                          input logic ld, input logic exp);
    @(negedge clk);
    drive(v, op, 1'b0, ld);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    pop_check(bus.y_q);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] bvals[3];
    rst_n = 1'b0;
    drive(32'h0, 3'd0, 1'b0, 1'b0);
    #12;
    check("reset_y_q", bus.y_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    comb("eq_zero",  32'h000000, 3'd0, 1'b0);
    comb("ne_zero",  32'h000000, 3'd1, 1'b0);
    comb("ne_one",   32'h000001, 3'd1, 1'b0);
    comb("lt_neg",   32'hF010FF, 3'd2, 1'b0);
    comb("ge_neg",   32'hF010FF, 3'd3, 1'b0);
    comb("lt_pos",   32'h7010FF, 3'd2, 1'b0);
    comb("ge_pos",   32'h7010FF, 3'd3, 1'b0);
    comb("le_zero",  32'h000000, 3'd4, 1'b0);
    comb("le_pos",   32'h7010FF, 3'd4, 1'b0);
    comb("gt_neg",   32'hF010FF, 3'd5, 1'b0);
    comb("gt_pos",   32'h7010FF, 3'd5, 1'b0);
    comb("ev_odd",   32'hF010FF, 3'd6, 1'b0);
    comb("od_odd",   32'hF010FF, 3'd7, 1'b0);
    comb("ev_even",  32'hF010FE, 3'd6, 1'b0);
    comb("od_even",  32'hF010FE, 3'd7, 1'b0);

    // Boundary operands across every condition code; upper bits must be ignored.
    bvals[0] = 32'h00000000;
    bvals[1] = 32'hAB800000;
    bvals[2] = 32'h00FFFFFF;
    for (int b = 0; b < 3; b++)
      for (int o = 0; o < 8; o++)
        comb("boundary", bvals[b], o[2:0], 1'b0);

    for (int i = 0; i < 40; i++) begin
      v = $urandom();
      if (i % 5 == 0) v = 32'h0;
      comb("random", v, 3'($urandom_range(7)), 1'b0);
    end

`ifdef TEST_COND_NEGATE_EN
    comb("neg_eq_zero", 32'h000000, 3'd0, 1'b1);
    comb("neg_lt_neg",  32'hF010FF, 3'd2, 1'b1);
    for (int i = 0; i < 20; i++)
      comb("neg_random", $urandom(), 3'($urandom_range(7)), 1'($urandom_range(1)));
`endif

    // Registered path: capture, hold, async reset, reset beats ld.
    reg_step("yq_capture1", 32'h000000, 3'd0, 1'b1, 1'b1);
    reg_step("yq_capture0", 32'h000001, 3'd0, 1'b1, 1'b0);
    reg_step("yq_capture2", 32'h000000, 3'd0, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("yq_async_reset", bus.y_q, 1'b0);
    check("y_during_reset", bus.y, 1'b1);
    reg_step("yq_reset_wins", 32'h000000, 3'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_step("yq_first_capture", 32'h000000, 3'd0, 1'b1, 1'b1);
    reg_step("yq_hold", 32'h000001, 3'd0, 1'b0, 1'b1);
    reg_step("yq_hold2", 32'h7010FF, 3'd2, 1'b0, 1'b1);
    reg_step("yq_gt_capture", 32'h7010FF, 3'd5, 1'b1, 1'b1);
    reg_step("yq_lt_capture", 32'h7010FF, 3'd2, 1'b1, 1'b0);

    check("scoreboard_drained", 1'(exp_q.size() == 0), 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
